// File: rtl/enc_buf_pkg.sv
// Shared types for the multibank encoder output buffer.
// Holds the drain FSM states and the read-mode encodings.
package enc_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERIAL = 2'd1,
      ST_PAR    = 2'd2
   } enc_buf_state_e;

   localparam logic RD_SERIAL = 1'b0;
   localparam logic RD_PAR    = 1'b1;

endpackage

// File: rtl/enc_buf_bank.sv
// One buffer bank: a LANES x DW word register with a valid flag.
// Clearing drops only the valid flag; the stale data is masked downstream.
module enc_buf_bank #(
   parameter int unsigned LANES = 4,
   parameter int unsigned DW    = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        load_i,
   input  logic                        clr_i,
   input  logic [LANES-1:0][DW-1:0]    data_i,
   output logic [LANES-1:0][DW-1:0]    data_o,
   output logic                        vld_o
);

   logic [LANES-1:0][DW-1:0] data_q;
   logic                     vld_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         if (load_i) begin
            data_q <= data_i;
         end
         if (clr_i) begin
            vld_q <= 1'b0;
         end else if (load_i) begin
            vld_q <= 1'b1;
         end
      end
   end

   assign data_o = data_q;
   assign vld_o  = vld_q;

endmodule

// File: rtl/enc_out_multibank_buffer.sv
// Multibank encoder output buffer: fills BANKS banks in order, then drains them
// either one bank per handshake or as a single one-cycle parallel snapshot.
module enc_out_multibank_buffer
   import enc_buf_pkg::*;
#(
   parameter int unsigned LANES = 4,
   parameter int unsigned DW    = 4,
   parameter int unsigned BANKS = 2,
   parameter int unsigned PW    = $clog2(BANKS)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [LANES-1:0][DW-1:0]              enc_data_i,
   input  logic                                  wr_en_i,
   output logic                                  wr_ready_o,
   input  logic                                  clr_i,
   input  logic                                  rd_mode_i,
   input  logic                                  rd_start_i,
   output logic [LANES-1:0][DW-1:0]              out_data_o,
   output logic [PW-1:0]                         out_bank_o,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic [BANKS-1:0][LANES-1:0][DW-1:0]   out_all_o,
   output logic                                  out_all_valid_o,
   output logic [$clog2(BANKS+1)-1:0]            count_o,
   output logic                                  full_o,
   output logic                                  empty_o,
   output logic                                  overflow_o
);

   localparam int unsigned CW = $clog2(BANKS + 1);

   enc_buf_state_e state_q;
   logic [CW-1:0]  wr_ptr_q;
   logic [CW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           overflow_q;

   logic                                 out_valid_q;
   logic [LANES-1:0][DW-1:0]             out_data_q;
   logic [PW-1:0]                        out_bank_q;
   logic                                 out_all_valid_q;
   logic [BANKS-1:0][LANES-1:0][DW-1:0]  out_all_q;

   logic [BANKS-1:0][LANES-1:0][DW-1:0]  bank_data;
   logic [BANKS-1:0]                     bank_vld;
   logic [BANKS-1:0]                     bank_load;
   logic [BANKS-1:0]                     bank_clr;
   logic [BANKS-1:0][LANES-1:0][DW-1:0]  view_data;
   logic [LANES-1:0][DW-1:0]             next_data;

   logic          full;
   logic          empty;
   logic          wr_ready;
   logic          wr_fire;
   logic          start_fire;
   logic          xfer;
   logic          last_xfer;
   logic [CW-1:0] rd_next;

   assign full       = (count_q == CW'(BANKS));
   assign empty      = (count_q == '0);
   assign wr_ready   = (state_q == ST_IDLE) && !full && !clr_i;
   assign wr_fire    = wr_en_i && wr_ready;
   // A write accepted alongside rd_start makes an empty buffer readable.
   assign start_fire = (state_q == ST_IDLE) && rd_start_i && !clr_i && (!empty || wr_fire);
   assign xfer       = (state_q == ST_SERIAL) && out_valid_q && out_ready_i;
   assign last_xfer  = xfer && (count_q == CW'(1));
   assign rd_next    = rd_ptr_q + CW'(1);

   // view_data is the bank contents as they will look after this edge's write,
   // so a same-cycle write is visible to the read that starts with it.
   always_comb begin
      bank_load = '0;
      bank_clr  = '0;
      view_data = '0;
      next_data = '0;
      for (int unsigned b = 0; b < BANKS; b++) begin
         bank_load[b] = wr_fire && (wr_ptr_q == CW'(b));
         bank_clr[b]  = clr_i || (state_q == ST_PAR) || (xfer && (rd_ptr_q == CW'(b)));
         if (bank_load[b]) begin
            view_data[b] = enc_data_i;
         end else if (bank_vld[b]) begin
            view_data[b] = bank_data[b];
         end
         if (rd_next == CW'(b)) begin
            next_data = bank_data[b];
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      enc_buf_bank #(
         .LANES (LANES),
         .DW    (DW)
      ) u_bank (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .load_i (bank_load[b]),
         .clr_i  (bank_clr[b]),
         .data_i (enc_data_i),
         .data_o (bank_data[b]),
         .vld_o  (bank_vld[b])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= ST_IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         overflow_q      <= 1'b0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_bank_q      <= '0;
         out_all_valid_q <= 1'b0;
         out_all_q       <= '0;
      end else if (clr_i) begin
         state_q         <= ST_IDLE;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         overflow_q      <= 1'b0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_bank_q      <= '0;
         out_all_valid_q <= 1'b0;
         out_all_q       <= '0;
      end else begin
         if (wr_en_i && !wr_ready) begin
            overflow_q <= 1'b1;
         end
         if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + CW'(1);
            count_q  <= count_q + CW'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (start_fire) begin
                  rd_ptr_q <= '0;
                  if (rd_mode_i == RD_PAR) begin
                     state_q         <= ST_PAR;
                     out_all_valid_q <= 1'b1;
                     out_all_q       <= view_data;
                  end else begin
                     state_q     <= ST_SERIAL;
                     out_valid_q <= 1'b1;
                     out_data_q  <= view_data[0];
                     out_bank_q  <= '0;
                  end
               end
            end
            ST_SERIAL: begin
               if (xfer) begin
                  count_q <= count_q - CW'(1);
                  if (last_xfer) begin
                     state_q     <= ST_IDLE;
                     out_valid_q <= 1'b0;
                     out_data_q  <= '0;
                     out_bank_q  <= '0;
                     wr_ptr_q    <= '0;
                     rd_ptr_q    <= '0;
                  end else begin
                     rd_ptr_q   <= rd_next;
                     out_data_q <= next_data;
                     out_bank_q <= rd_next[PW-1:0];
                  end
               end
            end
            ST_PAR: begin
               state_q         <= ST_IDLE;
               out_all_valid_q <= 1'b0;
               out_all_q       <= '0;
               wr_ptr_q        <= '0;
               rd_ptr_q        <= '0;
               count_q         <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wr_ready_o      = wr_ready;
   assign out_data_o      = out_data_q;
   assign out_bank_o      = out_bank_q;
   assign out_valid_o     = out_valid_q;
   assign out_all_o       = out_all_q;
   assign out_all_valid_o = out_all_valid_q;
   assign count_o         = count_q;
   assign full_o          = full;
   assign empty_o         = empty;
   assign overflow_o      = overflow_q;

endmodule
